mem_port_arbiter: RTL

- Shares the single-port unified program/data memory between the fetch stage (IF port) and the load/store path (LS port) of the pipelined core.
- Arbitrates between the two ports, sequences each access through a fixed-latency memory and routes read data back to the winning requester.
- At most one access in flight; fetch is protected from starvation.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_arb_pick.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared widths, owner codes and FSM states for the memory arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 3;

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_LS = 1'b1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, load/store and memory-side signals of the port arbiter.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
   parameter int ADDR_W = mem_arb_pkg::ADDR_W,
   parameter int DATA_W = mem_arb_pkg::DATA_W
);

   logic                  if_req;
   logic [ADDR_W-1:0]     if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [DATA_W-1:0]     if_rdata;

   logic                  ls_req;
   logic                  ls_we;
   logic [ADDR_W-1:0]     ls_addr;
   logic [DATA_W-1:0]     ls_wdata;
   logic [DATA_W/8-1:0]   ls_be;
   logic                  ls_gnt;
   logic                  ls_rvalid;
   logic [DATA_W-1:0]     ls_rdata;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic [DATA_W-1:0]     mem_rdata;

   logic                  busy;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
   );

endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Brief    : One-hot winner selection; MEMARB_ROUND_ROBIN_EN picks round-robin.
// Revision : 1.0
// ============================================================================
module mem_arb_pick
   import mem_arb_pkg::*;
`ifndef MEMARB_ROUND_ROBIN_EN
#(
   parameter int STARVE_MAX = 4,
   parameter int SC_W       = 3
)
`endif
(
   input  logic            if_req_i,
   input  logic            ls_req_i,
`ifdef MEMARB_ROUND_ROBIN_EN
   input  logic            last_ls_i,
`else
   input  logic [SC_W-1:0] starve_cnt_i,
`endif
   output logic [1:0]      gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (if_req_i && ls_req_i) begin
`ifdef MEMARB_ROUND_ROBIN_EN
         gnt_o[last_ls_i ? OWNER_IF : OWNER_LS] = 1'b1;
`else
         gnt_o[(starve_cnt_i >= SC_W'(STARVE_MAX)) ? OWNER_IF : OWNER_LS] = 1'b1;
`endif
      end else if (if_req_i) begin
         gnt_o[OWNER_IF] = 1'b1;
      end else if (ls_req_i) begin
         gnt_o[OWNER_LS] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one fixed-latency memory between fetch and load/store.
//            MEMARB_ROUND_ROBIN_EN swaps starvation override for round-robin.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [1:0]        pick_w;

`ifndef MEMARB_ROUND_ROBIN_EN
   localparam int SC_W = $clog2(STARVE_MAX + 1);
   logic [SC_W-1:0]   starve_q, starve_d;
`endif

   mem_arb_pick
`ifndef MEMARB_ROUND_ROBIN_EN
   #(
      .STARVE_MAX (STARVE_MAX),
      .SC_W       (SC_W)
   )
`endif
   u_pick (
      .if_req_i     (bus.if_req),
      .ls_req_i     (bus.ls_req),
`ifdef MEMARB_ROUND_ROBIN_EN
      .last_ls_i    (owner_q == OWNER_LS),
`else
      .starve_cnt_i (starve_q),
`endif
      .gnt_o        (pick_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         owner_q  <= OWNER_IF;
         we_q     <= 1'b0;
`ifndef MEMARB_ROUND_ROBIN_EN
         starve_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
`ifndef MEMARB_ROUND_ROBIN_EN
         starve_q <= starve_d;
`endif
      end
   end

   // Outputs are forced low during reset so an in-flight response is dropped.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      owner_d       = owner_q;
      we_d          = we_q;
`ifndef MEMARB_ROUND_ROBIN_EN
      starve_d      = starve_q;
`endif
      bus.if_gnt    = 1'b0;
      bus.if_rvalid = 1'b0;
      bus.if_rdata  = '0;
      bus.ls_gnt    = 1'b0;
      bus.ls_rvalid = 1'b0;
      bus.ls_rdata  = '0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_be    = '0;
      bus.busy      = 1'b0;

      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               if (pick_w[OWNER_IF]) begin
                  bus.if_gnt   = 1'b1;
                  bus.mem_en   = 1'b1;
                  bus.mem_addr = bus.if_addr;
                  bus.mem_be   = '1;
                  owner_d      = OWNER_IF;
                  we_d         = 1'b0;
`ifndef MEMARB_ROUND_ROBIN_EN
                  starve_d     = '0;
`endif
               end else if (pick_w[OWNER_LS]) begin
                  bus.ls_gnt    = 1'b1;
                  bus.mem_en    = 1'b1;
                  bus.mem_we    = bus.ls_we;
                  bus.mem_addr  = bus.ls_addr;
                  bus.mem_be    = bus.ls_be;
                  bus.mem_wdata = bus.ls_we ? bus.ls_wdata : '0;
                  owner_d       = OWNER_LS;
                  we_d          = bus.ls_we;
`ifndef MEMARB_ROUND_ROBIN_EN
                  if (bus.if_req && (starve_q < SC_W'(STARVE_MAX))) begin
                     starve_d = starve_q + SC_W'(1);
                  end
`endif
               end
               if (|pick_w) begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(MEM_LAT);
               end
            end
            ST_WAIT: begin
               bus.busy = 1'b1;
               cnt_d    = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  if (owner_q == OWNER_IF) begin
                     bus.if_rvalid = 1'b1;
                     bus.if_rdata  = bus.mem_rdata;
                  end else begin
                     bus.ls_rvalid = 1'b1;
                     bus.ls_rdata  = we_q ? '0 : bus.mem_rdata;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
